stripes_serial_ctrl: RTL and testbench
======================================

STRIPES_SERIAL_CTRL -- requirements
Module: stripes_serial_ctrl

Interface
REQ-001 Parameter: N, 16, synapse/partial-sum bit width.
REQ-002 Parameter: PIPE_LAT, 1, adder-tree pipeline register depth in the serial inner-product array.
REQ-003 Parameter: BW, 16, width of brick counter.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_start  input  1  job request; accepted only when o_ready=1.
REQ-007 o_ready  output  1  high only in IDLE.
REQ-008 i_precision  input  5  neuron bits per brick (P), sampled on accept.
REQ-009 i_max  input  1  max-pooling mode, sampled on accept.
REQ-010 i_num_bricks  input  BW  bricks in job (K), sampled on accept.
REQ-011 o_nb_rd_en  output  1  neuron-bit fetch strobe; neuron buffer drives zero bits when low.
REQ-012 o_bit_idx  output  4  bit position fetched, MSB first.
REQ-013 o_brick_idx  output  BW  current brick, 0..K-1.
REQ-014 o_first_cycle  output  1  MSB cycle flag to complement stage.
REQ-015 o_acc_first  output  1  o_first_cycle delayed PIPE_LAT cycles, to accumulator.
REQ-016 o_dp_reset  output  1  datapath accumulator reset.
REQ-017 o_max  output  1  latched i_max, held for whole job.
REQ-018 o_precision  output  5  latched effective P.
REQ-019 o_wr_en  output  1  single-cycle NBout write strobe; no backpressure.
REQ-020 o_done  output  1  single-cycle job-complete pulse.

Function
REQ-021 States: IDLE, STREAM, DRAIN, WRITE, DONE.
REQ-022 IDLE: o_ready=1, o_dp_reset=1; i_start=1 -> latch inputs, brick=0, bit counter=P-1, go STREAM (K>0) or DONE (K=0).
REQ-023 Effective P: i_precision 0 or >16 -> 16; else i_precision.
REQ-024 STREAM: o_nb_rd_en=1, o_bit_idx=bit counter, counter decrements each cycle; exactly P cycles.
REQ-025 o_first_cycle=1 only in first STREAM cycle of each brick (bit_idx=P-1).
REQ-026 o_acc_first equals o_first_cycle registered through PIPE_LAT stages; delay line cleared by reset.
REQ-027 STREAM with bit counter=0 -> DRAIN next cycle.
REQ-028 DRAIN: o_nb_rd_en=0; lasts exactly PIPE_LAT+1 cycles (drain counter), then WRITE.
REQ-029 WRITE: o_wr_en=1 for exactly one cycle; o_brick_idx unchanged in that cycle.
REQ-030 WRITE -> STREAM with brick+1 and bit counter reloaded to P-1 if brick<K-1; else DONE.
REQ-031 Per-brick period = P+PIPE_LAT+2 cycles; job = 1+K*(P+PIPE_LAT+2) cycles from accept to o_done.
REQ-032 DONE: o_done=1 one cycle, then IDLE.
REQ-033 i_start ignored outside IDLE; inputs change mid-job have no effect.
REQ-034 o_dp_reset=0 in STREAM, DRAIN, WRITE, DONE.
REQ-035 K=2^BW-1 completes without counter wrap; o_brick_idx never exceeds K-1.
REQ-036 o_wr_en, o_nb_rd_en, o_first_cycle never asserted outside stated states.

Reset
REQ-037 reset=1 -> next state IDLE regardless of current state; all counters 0.
REQ-038 Reset values: o_ready=1, o_dp_reset=1, o_max=0, o_precision=16, o_bit_idx=0, o_brick_idx=0; all strobes 0.
REQ-039 Reset mid-STREAM/DRAIN/WRITE: no o_wr_en or o_done produced for aborted job.

Verification
REQ-040 P=8, K=1, PIPE_LAT=1: start -> o_bit_idx 7..0 on cycles 1..8, o_first_cycle cycle 1, o_acc_first cycle 2, o_wr_en cycle 11, o_done cycle 12.
REQ-041 P=16, K=3: three o_wr_en pulses spaced 19 cycles, o_brick_idx 0,1,2 at each; one o_done.
REQ-042 i_precision=0 and =20: behaves as P=16; i_num_bricks=0: o_done cycle after accept, no o_wr_en.
REQ-043 i_start held high through job with i_max toggling: single job, o_max constant, new job accepted only after return to IDLE.
REQ-044 reset asserted during third STREAM cycle: next cycle IDLE, o_ready=1, no o_wr_en/o_done; fresh start completes normally.
REQ-045 P=1, K=2: o_first_cycle every STREAM cycle; o_wr_en at cycles 4 and 8.

Source files
------------

// File: rtl/stripes_serial_ctrl_if.sv
// Job handshake and datapath-control bundle between the serial inner-product
// controller (slave) and its job issuer / datapath (master).
interface stripes_serial_ctrl_if #(
  parameter int BW = 16
);
  logic          i_start;
  logic          o_ready;
  logic [4:0]    i_precision;
  logic          i_max;
  logic [BW-1:0] i_num_bricks;
  logic          o_nb_rd_en;
  logic [3:0]    o_bit_idx;
  logic [BW-1:0] o_brick_idx;
  logic          o_first_cycle;
  logic          o_acc_first;
  logic          o_dp_reset;
  logic          o_max;
  logic [4:0]    o_precision;
  logic          o_wr_en;
  logic          o_done;

  modport master (
    output i_start, i_precision, i_max, i_num_bricks,
    input  o_ready, o_nb_rd_en, o_bit_idx, o_brick_idx, o_first_cycle,
           o_acc_first, o_dp_reset, o_max, o_precision, o_wr_en, o_done
  );

  modport slave (
    input  i_start, i_precision, i_max, i_num_bricks,
    output o_ready, o_nb_rd_en, o_bit_idx, o_brick_idx, o_first_cycle,
           o_acc_first, o_dp_reset, o_max, o_precision, o_wr_en, o_done
  );
endinterface

// File: rtl/stripes_serial_ctrl.sv
// Bit-serial brick sequencer: streams P neuron bits MSB-first per brick, drains
// the adder-tree pipeline, writes one result per brick, then signals done.
module stripes_serial_ctrl #(
  parameter int N        = 16,
  parameter int PIPE_LAT = 1,
  parameter int BW       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  stripes_serial_ctrl_if.slave   bus
);

  localparam int DW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_WRITE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    bit_q, bit_d;
  logic [BW-1:0] brick_q, brick_d;
  logic [BW-1:0] k_q, k_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          max_q, max_d;
  logic [4:0]    prec_q, prec_d;
  logic [4:0]    eff_p;

  // Precision outside 1..N means "full width".
  assign eff_p = (bus.i_precision == 5'd0 || bus.i_precision > 5'(N)) ? 5'(N) : bus.i_precision;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      brick_q <= '0;
      k_q     <= '0;
      drain_q <= '0;
      max_q   <= 1'b0;
      prec_q  <= 5'(N);
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      brick_q <= brick_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      max_q   <= max_d;
      prec_q  <= prec_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    brick_d = brick_q;
    k_d     = k_q;
    drain_d = drain_q;
    max_d   = max_q;
    prec_d  = prec_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          max_d   = bus.i_max;
          prec_d  = eff_p;
          k_d     = bus.i_num_bricks;
          bit_d   = 4'(eff_p - 5'd1);
          brick_d = '0;
          drain_d = '0;
          state_d = (bus.i_num_bricks == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (bit_q == 4'd0) begin
          drain_d = DW'(PIPE_LAT);
          state_d = S_DRAIN;
        end else begin
          bit_d = bit_q - 4'd1;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_WRITE;
        else               drain_d = drain_q - DW'(1);
      end
      S_WRITE: begin
        // Compare against K-1 rather than incrementing first, so K = 2^BW-1 never wraps.
        if (brick_q == k_q - BW'(1)) begin
          state_d = S_DONE;
        end else begin
          brick_d = brick_q + BW'(1);
          bit_d   = 4'(prec_q - 5'd1);
          state_d = S_STREAM;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_ready       = (state_q == S_IDLE);
  assign bus.o_dp_reset    = (state_q == S_IDLE);
  assign bus.o_nb_rd_en    = (state_q == S_STREAM);
  assign bus.o_bit_idx     = bit_q;
  assign bus.o_brick_idx   = brick_q;
  assign bus.o_first_cycle = (state_q == S_STREAM) && (bit_q == 4'(prec_q - 5'd1));
  assign bus.o_wr_en       = (state_q == S_WRITE);
  assign bus.o_done        = (state_q == S_DONE);
  assign bus.o_max         = max_q;
  assign bus.o_precision   = prec_q;

  // The accumulator sees the MSB flag aligned with the adder-tree output.
  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign bus.o_acc_first = bus.o_first_cycle;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0] acc_pipe_q;
      always_ff @(posedge clk) begin
        if (reset) acc_pipe_q <= '0;
        else       acc_pipe_q <= (acc_pipe_q << 1) | PIPE_LAT'(bus.o_first_cycle);
      end
      assign bus.o_acc_first = acc_pipe_q[PIPE_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_stripes_serial_ctrl.sv
// Randomized self-checking bench for stripes_serial_ctrl against a cycle-offset
// arithmetic model of the brick schedule.
module tb_stripes_serial_ctrl;
  localparam int N        = 16;
  localparam int PIPE_LAT = 1;
  localparam int BW       = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stripes_serial_ctrl_if #(.BW(BW)) bus();

  stripes_serial_ctrl #(.N(N), .PIPE_LAT(PIPE_LAT), .BW(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit last_max;

  // True when offset c (1 = first cycle after accept) is the MSB cycle of a brick.
  function automatic bit first_at(int c, int k, int period);
    return (c >= 1) && (c <= k * period) && (((c - 1) % period) == 0);
  endfunction

  // Runs one job from an IDLE negedge and compares every output each cycle.
  // Inputs are scrambled after accept; they must have no effect.
  task automatic run_job(input string tag, input int p_in, input bit mx, input int k,
                         input bit hold, output int wr_cnt, output int done_cnt);
    int p, period, last, b, r;
    bit in_job, e_stream, e_first, e_acc, e_wr, e_done, e_idle;
    p      = (p_in == 0 || p_in > 16) ? 16 : p_in;
    period = p + PIPE_LAT + 2;
    last   = k * period + 1;
    wr_cnt = 0;
    done_cnt = 0;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept_ready got %b want 1", tag, bus.o_ready);
    end
    bus.i_start      = 1'b1;
    bus.i_precision  = 5'(p_in);
    bus.i_max        = mx;
    bus.i_num_bricks = BW'(k);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      in_job   = (c <= k * period);
      b        = in_job ? (c - 1) / period : 0;
      r        = in_job ? (c - 1) % period : 0;
      e_stream = in_job && (r < p);
      e_first  = first_at(c, k, period);
      e_acc    = first_at(c - PIPE_LAT, k, period);
      e_wr     = in_job && (r == period - 1);
      e_done   = (c == last);
      e_idle   = (c == last + 1);
      if (bus.o_wr_en === 1'b1) wr_cnt++;
      if (bus.o_done === 1'b1) done_cnt++;
      checks++;
      if (bus.o_ready !== e_idle || bus.o_dp_reset !== e_idle) begin
        errors++; $display("FAIL %s c=%0d ready/dp_reset got %b/%b want %b", tag, c,
                           bus.o_ready, bus.o_dp_reset, e_idle);
      end
      checks++;
      if (bus.o_nb_rd_en !== e_stream) begin
        errors++; $display("FAIL %s c=%0d nb_rd_en got %b want %b", tag, c, bus.o_nb_rd_en, e_stream);
      end
      checks++;
      if (bus.o_first_cycle !== e_first || bus.o_acc_first !== e_acc) begin
        errors++; $display("FAIL %s c=%0d first/acc_first got %b/%b want %b/%b", tag, c,
                           bus.o_first_cycle, bus.o_acc_first, e_first, e_acc);
      end
      checks++;
      if (bus.o_wr_en !== e_wr || bus.o_done !== e_done) begin
        errors++; $display("FAIL %s c=%0d wr_en/done got %b/%b want %b/%b", tag, c,
                           bus.o_wr_en, bus.o_done, e_wr, e_done);
      end
      checks++;
      if (bus.o_max !== mx || bus.o_precision !== 5'(p)) begin
        errors++; $display("FAIL %s c=%0d max/precision got %b/%0d want %b/%0d", tag, c,
                           bus.o_max, bus.o_precision, mx, p);
      end
      if (e_stream) begin
        checks++;
        if (bus.o_bit_idx !== 4'(p - 1 - r)) begin
          errors++; $display("FAIL %s c=%0d bit_idx got %0d want %0d", tag, c, bus.o_bit_idx, p - 1 - r);
        end
      end
      if (in_job) begin
        checks++;
        if (bus.o_brick_idx !== BW'(b)) begin
          errors++; $display("FAIL %s c=%0d brick_idx got %0d want %0d", tag, c, bus.o_brick_idx, b);
        end
      end
      if (c == last + 1) begin
        // Values presented to a possible back-to-back accept: an empty job.
        last_max         = ~mx;
        bus.i_precision  = 5'd1;
        bus.i_max        = last_max;
        bus.i_num_bricks = '0;
      end else begin
        bus.i_precision  = 5'($urandom);
        bus.i_max        = 1'($urandom);
        bus.i_num_bricks = BW'($urandom);
      end
      bus.i_start = hold ? 1'b1 : 1'b0;
    end
    checks++;
    if (wr_cnt != k || done_cnt != 1) begin
      errors++; $display("FAIL %s pulse_count wr=%0d done=%0d want wr=%0d done=1", tag, wr_cnt, done_cnt, k);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_dp_reset !== 1'b1 || bus.o_max !== 1'b0 ||
        bus.o_precision !== 5'd16 || bus.o_bit_idx !== 4'd0 || bus.o_brick_idx !== '0) begin
      errors++; $display("FAIL %s reset_regs got ready=%b dpr=%b max=%b prec=%0d bit=%0d brick=%0d",
                         tag, bus.o_ready, bus.o_dp_reset, bus.o_max, bus.o_precision,
                         bus.o_bit_idx, bus.o_brick_idx);
    end
    checks++;
    if (bus.o_nb_rd_en !== 1'b0 || bus.o_first_cycle !== 1'b0 || bus.o_acc_first !== 1'b0 ||
        bus.o_wr_en !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++; $display("FAIL %s reset_strobes got rd=%b first=%b acc=%b wr=%b done=%b want all 0",
                         tag, bus.o_nb_rd_en, bus.o_first_cycle, bus.o_acc_first, bus.o_wr_en, bus.o_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset_release");
  endtask

  task automatic test_single();
    int w, d;
    run_job("single_p8_k1", 8, 1'b1, 1, 1'b0, w, d);
  endtask

  task automatic test_multi_brick();
    int w, d;
    run_job("p16_k3", 16, 1'b0, 3, 1'b0, w, d);
  endtask

  task automatic test_precision_clamp();
    int w, d;
    run_job("prec0", 0, 1'b1, 2, 1'b0, w, d);
    run_job("prec20", 20, 1'b0, 1, 1'b0, w, d);
  endtask

  task automatic test_zero_bricks();
    int w, d;
    run_job("k0", 5, 1'b1, 0, 1'b0, w, d);
  endtask

  task automatic test_p1();
    int w, d;
    run_job("p1_k2", 1, 1'b0, 2, 1'b0, w, d);
  endtask

  task automatic test_random();
    int w, d;
    for (int i = 0; i < 12; i++)
      run_job($sformatf("rand%0d", i), int'($urandom_range(0, 31)), 1'($urandom),
              int'($urandom_range(1, 4)), 1'b0, w, d);
  endtask

  task automatic test_back_to_back();
    int w, d;
    run_job("held_start", 6, 1'b1, 2, 1'b1, w, d);
    // The held start is accepted on the IDLE cycle, launching the empty job.
    @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_done !== 1'b1 || bus.o_max !== last_max) begin
      errors++; $display("FAIL held_second_accept got ready=%b done=%b max=%b want 0/1/%b",
                         bus.o_ready, bus.o_done, bus.o_max, last_max);
    end
    bus.i_start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++; $display("FAIL held_return_idle got ready=%b want 1", bus.o_ready);
    end
  endtask

  task automatic test_reset_midjob();
    int w, d, bad;
    bus.i_start = 1'b1; bus.i_precision = 5'd8; bus.i_max = 1'b1; bus.i_num_bricks = BW'(2);
    repeat (3) begin
      @(negedge clk);
      bus.i_start = 1'b0;
    end
    checks++;
    if (bus.o_nb_rd_en !== 1'b1 || bus.o_bit_idx !== 4'd5) begin
      errors++; $display("FAIL midjob_third_stream got rd=%b bit=%0d want 1/5", bus.o_nb_rd_en, bus.o_bit_idx);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midjob_reset");
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.o_wr_en !== 1'b0 || bus.o_done !== 1'b0 || bus.o_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL aborted_job_quiet got %0d bad cycles want 0", bad);
    end
    run_job("after_reset", 3, 1'b0, 2, 1'b0, w, d);
  endtask

  initial begin
    reset = 1'b1;
    bus.i_start = 1'b0;
    bus.i_precision = '0;
    bus.i_max = 1'b0;
    bus.i_num_bricks = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_multi_brick();
    test_precision_clamp();
    test_zero_bricks();
    test_p1();
    test_random();
    test_back_to_back();
    test_reset_midjob();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
